ods_ctrl: RTL and testbench
===========================

# ods_ctrl

Sequencer for the 3-row, 2-stage output data shifter (ODS) in the device output path. Accepts a valid/ready stream of result words and steers each one into the correct ODS row through `sel_out`. Pulses `shift` to move a completed group of three into the ODS output stage. Presents that group downstream with a valid/ready handshake, so the next group can be collected while the previous one waits.

## Interface
- `GROUP_CNT_WIDTH`, 16, width of the emitted-group counter.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `arst_n_in` in 1: reset, synchronous and active-low. Despite the name, it is sampled only on `clk`.
- `in_valid` in 1: upstream result word is valid this cycle.
- `in_ready` out 1: controller accepts the word this cycle.
- `sel_out` out 2: ODS row write select.
  - 0, 1 or 2 writes ODS row 1, 2 or 3 respectively.
  - 3 means no write.
- `shift` out 1: ODS column-1 to column-2 transfer enable.
- `out_valid` out 1: the ODS outputs `out_1..out_3` hold a group.
- `out_ready` in 1: downstream consumes the group.
- `out_mask` out 3: rows of the presented group that carry data; bit0 = row 1.
- `flush` in 1: force shift of a partial group. Present only with `ODS_CTRL_FLUSH_EN`.
- `group_cnt` out GROUP_CNT_WIDTH: number of groups consumed downstream.

## Operation
- State:
  - `fill_cnt` (0..3): words currently in ODS column 1.
  - `stage_full`: column 2 holds an unconsumed group.
  - `fill_mask` (3 bits): rows written in column 1.
  - `stage_mask`: copy of `fill_mask` latched on shift.
  - `group_cnt`.
- `pop = out_valid && out_ready`; `out_valid = stage_full`; `out_mask = stage_mask`.
- `shift = (fill_cnt == 3 || flush_req) && (!stage_full || pop)`.
  - `flush_req = flush && fill_cnt != 0` with the macro; otherwise 0.
- `in_ready = fill_cnt < 3 || shift`. Also forced to 0 during a flush shift, so a partial group is never mixed with a new word.
- `accept = in_valid && in_ready`.
- `sel_out`:
  - When `accept`: equals `shift ? 0 : fill_cnt`.
  - Otherwise: 3.
  - Combinational, same cycle as `accept`.
- Next state:
  - `fill_cnt = (shift ? 0 : fill_cnt) + accept`. `fill_mask` follows the same rule, setting the written row's bit.
  - `stage_full = shift | (stage_full & !pop)`. On `shift`, `stage_mask` takes `fill_mask`.
  - `group_cnt` increments on `pop` and wraps modulo 2^GROUP_CNT_WIDTH.
- Simultaneous events:
  - Shift plus accept in one cycle is legal. The old column 1 moves to column 2 while the new word lands in row 1.
  - Pop plus shift in one cycle keeps `stage_full` = 1 with the new mask.
- `flush` with `fill_cnt == 0` has no effect.
  - A flush blocked by a full stage stays pending only while `flush` is held. `flush` is a level, not latched.

## Timing
- Reset (`arst_n_in` low at an edge) values:
  - `fill_cnt` = 0, `fill_mask` = 0, `stage_full` = 0, `stage_mask` = 0, `group_cnt` = 0.
  - Hence `out_valid` = 0, `shift` = 0, `sel_out` = 3, `in_ready` = 1.
- A reset in the middle of a group discards any partial or staged group with no output.
- `in_ready`, `sel_out` and `shift` are combinational from state and inputs. `in_ready` depends on `out_ready` through `shift`.
- Latency:
  - The third word is accepted in cycle N.
  - `shift` asserts in cycle N+1 if the stage is empty.
  - `out_valid` rises in cycle N+2.
- Throughput: one word per cycle sustained when `out_ready` is held high.

## Configuration
- `ODS_CTRL_FLUSH_EN` defined:
  - `flush` port exists.
  - Partial groups can be shifted, and `out_mask` reports the rows written.
- Undefined:
  - No `flush` port.
  - Shift only on a full group.
  - `stage_mask` is constant 3'b111 (`out_mask` = 3'b111 whenever `out_valid`).

## Structure
- Shared package `ods_pkg`:
  - `ODS_ROWS = 3`.
  - `ODS_SEL_IDLE = 2'b11`.
  - typedef `ods_sel_t` (logic [1:0]).
  - typedef `ods_mask_t` (logic [2:0]).
- No sub-module. A single flat FSM/counter block instantiated beside ODS in the output wrapper.

## Test plan
- Reset, then idle → `sel_out` = 3, `shift` = 0, `out_valid` = 0, `in_ready` = 1, `group_cnt` = 0.
- Words A, B, C on consecutive cycles with `out_ready` = 1:
  - `sel_out` = 0, 1, 2.
  - `shift` one cycle later.
  - `out_valid` with outputs A, B, C and `out_mask` = 3'b111.
  - `group_cnt` = 1.
- Stream of 9 words with `out_ready` = 0:
  - After 6 accepts, `in_ready` = 0 and `shift` = 0.
  - Raising `out_ready` shifts, pops, and the stream resumes.
  - After the last group pops, `group_cnt` = 3.
- Shift and accept in the same cycle → `sel_out` = 0, `shift` = 1. Next cycle `fill_cnt` = 1 and `stage_mask` = 3'b111.
- With `ODS_CTRL_FLUSH_EN`: two words, then `flush` = 1:
  - `shift` = 1 and `in_ready` = 0 in that cycle.
  - `out_mask` = 3'b011.
  - `flush` with an empty column 1 causes no shift.
- `arst_n_in` low while `fill_cnt` = 2 and `stage_full` = 1 → the next cycle shows all reset values, and no `out_valid` follows.

Source files
------------

// File: rtl/ods_pkg.sv
// Shared types and constants for the output data shifter (ODS) sequencer.
// Row selects and row masks are shared with the ODS datapath wrapper.
package ods_pkg;

    localparam int         ODS_ROWS     = 3;
    localparam logic [1:0] ODS_SEL_IDLE = 2'b11;

    typedef logic [1:0] ods_sel_t;
    typedef logic [2:0] ods_mask_t;

    // One-hot row bit for a row select; the idle select maps to no row.
    function automatic ods_mask_t ods_row_bit(input ods_sel_t sel);
        ods_mask_t bit_v;
        bit_v = '0;
        for (int r = 0; r < ODS_ROWS; r++) begin
            if (sel == ods_sel_t'(r)) begin
                bit_v[r] = 1'b1;
            end
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/ods_ctrl.sv
// Sequencer for the 3-row, 2-stage ODS: steers words into column-1 rows, shifts full groups to column 2, and hands them downstream.
// Build option ODS_CTRL_FLUSH_EN adds the flush input so partial groups can be shifted with their row mask.
module ods_ctrl
    import ods_pkg::*;
#(
    parameter int GROUP_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       arst_n_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output ods_sel_t                   sel_out,
    output logic                       shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output ods_mask_t                  out_mask,
`ifdef ODS_CTRL_FLUSH_EN
    input  logic                       flush,
`endif
    output logic [GROUP_CNT_WIDTH-1:0] group_cnt
);

    logic [1:0]                 fill_cnt_q, fill_cnt_d;
    logic                       stage_full_q, stage_full_d;
    logic [GROUP_CNT_WIDTH-1:0] group_cnt_q, group_cnt_d;

    logic     pop;
    logic     group_full;
    logic     flush_req;
    logic     shift_c;
    logic     in_ready_c;
    logic     accept;
    ods_sel_t wr_row;

`ifdef ODS_CTRL_FLUSH_EN
    ods_mask_t fill_mask_q, fill_mask_d;
    ods_mask_t stage_mask_q, stage_mask_d;

    assign flush_req = flush && (fill_cnt_q != 2'd0);
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        pop        = stage_full_q && out_ready;
        group_full = (fill_cnt_q == 2'd3);
        shift_c    = (group_full || flush_req) && (!stage_full_q || pop);
        // A flush shift blocks input so a partial group never shares a cycle with a new word.
        in_ready_c = (!group_full || shift_c) && !(shift_c && flush_req);
        accept     = in_valid && in_ready_c;
        wr_row     = shift_c ? ods_sel_t'(2'd0) : ods_sel_t'(fill_cnt_q);
    end

    always_comb begin
        fill_cnt_d   = (shift_c ? 2'd0 : fill_cnt_q) + {1'b0, accept};
        stage_full_d = shift_c || (stage_full_q && !pop);
        group_cnt_d  = group_cnt_q + GROUP_CNT_WIDTH'(pop);
    end

`ifdef ODS_CTRL_FLUSH_EN
    always_comb begin
        fill_mask_d  = (shift_c ? ods_mask_t'('0) : fill_mask_q)
                     | (accept ? ods_row_bit(wr_row) : ods_mask_t'('0));
        stage_mask_d = shift_c ? fill_mask_q : stage_mask_q;
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            fill_mask_q  <= '0;
            stage_mask_q <= '0;
        end else begin
            fill_mask_q  <= fill_mask_d;
            stage_mask_q <= stage_mask_d;
        end
    end

    assign out_mask = stage_mask_q;
`else
    // Without flush only complete groups are ever staged.
    assign out_mask = 3'b111;
`endif

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            fill_cnt_q   <= 2'd0;
            stage_full_q <= 1'b0;
            group_cnt_q  <= '0;
        end else begin
            fill_cnt_q   <= fill_cnt_d;
            stage_full_q <= stage_full_d;
            group_cnt_q  <= group_cnt_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign shift     = shift_c;
    assign sel_out   = accept ? wr_row : ODS_SEL_IDLE;
    assign out_valid = stage_full_q;
    assign group_cnt = group_cnt_q;

endmodule

// File: tb/tb_ods_ctrl.sv
// Bench for ods_ctrl: directed scenarios plus random traffic checked against a queue-based model of the two ODS columns.
// The flush scenarios are compiled in only when ODS_CTRL_FLUSH_EN is defined.
module tb_ods_ctrl;
    import ods_pkg::*;

`ifdef ODS_CTRL_FLUSH_EN
    localparam bit FLUSH_BUILD = 1'b1;
`else
    localparam bit FLUSH_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        in_valid;
    logic        in_ready;
    ods_sel_t    sel_out;
    logic        shift;
    logic        out_valid;
    logic        out_ready;
    ods_mask_t   out_mask;
    logic [15:0] group_cnt;
`ifdef ODS_CTRL_FLUSH_EN
    logic        flush;
`endif

    always #5 clk = ~clk;

    ods_ctrl #(.GROUP_CNT_WIDTH(16)) dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel_out   (sel_out),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
`ifdef ODS_CTRL_FLUSH_EN
        .flush     (flush),
`endif
        .group_cnt (group_cnt)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Model: column 1 is the list of rows written so far, the stage holds masks of shifted groups.
    int          col1[$];
    ods_mask_t   stage_q[$];
    int          groups_m;
    int          words;
    logic        m_shift, m_ready, m_accept;
    logic [1:0]  m_sel;
    logic        o_shift, o_ready, o_valid;
    logic [1:0]  o_sel;
    logic [2:0]  o_mask;
    logic [15:0] o_gcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic vin, input logic ordy, input logic fl);
        logic      vld, pop, freq;
        ods_mask_t gm;
        in_valid  = vin;
        out_ready = ordy;
`ifdef ODS_CTRL_FLUSH_EN
        flush     = fl;
`endif
        #2;
        vld      = (stage_q.size() != 0);
        pop      = vld && ordy;
        freq     = FLUSH_BUILD && fl && (col1.size() != 0);
        m_shift  = ((col1.size() == 3) || freq) && (!vld || pop);
        m_ready  = ((col1.size() < 3) || m_shift) && !(m_shift && freq);
        m_accept = vin && m_ready;
        m_sel    = m_accept ? (m_shift ? 2'd0 : 2'(col1.size())) : 2'd3;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("sel_out", 32'(sel_out), 32'(m_sel));
        chk("shift", 32'(shift), 32'(m_shift));
        chk("out_valid", 32'(out_valid), 32'(vld));
        chk("group_cnt", 32'(group_cnt), 32'(groups_m));
        if (vld) chk("out_mask", 32'(out_mask), 32'(stage_q[0]));
        o_shift = shift;
        o_ready = in_ready;
        o_valid = out_valid;
        o_sel   = sel_out;
        o_mask  = out_mask;
        o_gcnt  = group_cnt;
        gm = '0;
        foreach (col1[i]) gm |= ods_mask_t'(1 << col1[i]);
        @(posedge clk);
        if (!arst_n_in) begin
            col1.delete();
            stage_q.delete();
            groups_m = 0;
            words    = 0;
        end else begin
            if (pop) begin
                void'(stage_q.pop_front());
                groups_m = (groups_m + 1) % 65536;
            end
            if (m_shift) begin
                stage_q.push_back(gm);
                col1.delete();
            end
            if (m_accept) begin
                col1.push_back(int'(m_sel));
                words++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        arst_n_in = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        arst_n_in = 1'b1;
    endtask

    initial begin
        arst_n_in = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef ODS_CTRL_FLUSH_EN
        flush     = 1'b0;
`endif
        groups_m  = 0;
        words     = 0;
        repeat (2) @(posedge clk);
        #1;
        arst_n_in = 1'b1;

        // Idle after reset.
        cycle(1'b0, 1'b0, 1'b0);
        chk("rst_sel", 32'(o_sel), 32'd3);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_shift", 32'(o_shift), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_gcnt", 32'(o_gcnt), 32'd0);

        // Words A..E with downstream ready; D arrives in the shift cycle.
        cycle(1'b1, 1'b1, 1'b0); chk("sel_a", 32'(o_sel), 32'd0);
        cycle(1'b1, 1'b1, 1'b0); chk("sel_b", 32'(o_sel), 32'd1);
        cycle(1'b1, 1'b1, 1'b0); chk("sel_c", 32'(o_sel), 32'd2);
        cycle(1'b1, 1'b1, 1'b0);
        chk("shacc_sel", 32'(o_sel), 32'd0);
        chk("shacc_shift", 32'(o_shift), 32'd1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("abc_valid", 32'(o_valid), 32'd1);
        chk("abc_mask", 32'(o_mask), 32'b111);
        chk("after_shacc_sel", 32'(o_sel), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("abc_gcnt", 32'(o_gcnt), 32'd1);

        // Nine words against a stalled downstream.
        do_reset();
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        chk("stall_words", words, 6);
        cycle(1'b1, 1'b0, 1'b0);
        chk("stall_ready", 32'(o_ready), 32'd0);
        chk("stall_shift", 32'(o_shift), 32'd0);
        for (int i = 0; i < 16; i++) cycle(words < 9, 1'b1, 1'b0);
        chk("stream_gcnt", 32'(group_cnt), 32'd3);

        // Reset with two words in column 1 and a staged group.
        do_reset();
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_sel", 32'(o_sel), 32'd3);
        chk("midrst_gcnt", 32'(o_gcnt), 32'd0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0);

`ifdef ODS_CTRL_FLUSH_EN
        do_reset();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("flush_shift", 32'(o_shift), 32'd1);
        chk("flush_ready", 32'(o_ready), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("flush_valid", 32'(o_valid), 32'd1);
        chk("flush_mask", 32'(o_mask), 32'b011);
        cycle(1'b0, 1'b1, 1'b1);
        chk("flush_empty_shift", 32'(o_shift), 32'd0);
`endif

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            arst_n_in = ($urandom_range(0, 99) != 0);
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0);
        end
        arst_n_in = 1'b1;
        repeat (8) cycle(1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
